mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, fixed-latency SRAM macro between NUM_PORTS requesters.
//  Requesters are the core instruction port, the core data port and the debug module
//  system-bus master.
//  Requesters use the core's req/gnt/rvalid protocol; arbitration is round-robin.
//  Each response is routed back to the port that owns it.
//  Sits between the core/DM masters and the SRAM, in place of per-master bus bridges.
// PARAMETERS
//  NUM_PORTS   3   number of requesters, >= 2
//  ADDR_WIDTH  32  byte address width
//  DATA_WIDTH  32  data width; byte enables are DATA_WIDTH/8 bits
//  IDX_W       $clog2(NUM_PORTS)  derived, not overridable
// PORTS
//  clk_i        in   1                     clock, all logic on rising edge
//  rst_i        in   1                     synchronous reset, active-high
//  req_i        in   NUM_PORTS             per-port request
//  gnt_o        out  NUM_PORTS             per-port grant, one-hot or zero
//  we_i         in   NUM_PORTS             per-port write enable
//  addr_i       in   NUM_PORTS*ADDR_WIDTH  per-port address, port p at [p*AW +: AW]
//  be_i         in   NUM_PORTS*DW/8        per-port byte enables
//  wdata_i      in   NUM_PORTS*DW          per-port write data
//  rvalid_o     out  NUM_PORTS             per-port response valid, one-hot or zero
//  rdata_o      out  DATA_WIDTH            shared read data, valid when any rvalid_o bit is set
//  mem_req_o    out  1                     SRAM access strobe
//  mem_we_o     out  1                     SRAM write enable
//  mem_addr_o   out  ADDR_WIDTH            SRAM byte address, passed through unchanged
//  mem_be_o     out  DW/8                  SRAM byte enables
//  mem_wdata_o  out  DW                    SRAM write data
//  mem_rdata_i  in   DW                    SRAM read data, valid 1 cycle after mem_req_o
//  grant_idx_o  out  IDX_W                 index of the most recent grant (debug/perf)
// BEHAVIOUR
//  - Protocol: requester holds req/we/addr/be/wdata stable until gnt_o. A request is
//    accepted in the cycle req_i[p] && gnt_o[p]. gnt_o is combinational from req_i.
//  - At most one grant per cycle. A new grant may be issued every cycle (full throughput).
//  - Round-robin: rr_ptr holds the last granted index. Search order is rr_ptr+1,
//    rr_ptr+2, ..., wrapping modulo NUM_PORTS. The first requesting port wins.
//    rr_ptr updates only on a grant.
//  - Sole requester: the same port is granted on consecutive cycles without bubbles.
//  - No request: gnt_o=0, mem_req_o=0, rr_ptr holds.
//  - Memory drive: mem_req_o = |gnt_o. mem_we/addr/be/wdata are muxed from the granted
//    port. They are don't-care when mem_req_o=0 but must not be X; drive port 0 fields.
//  - Response: resp_vld and resp_idx are registered on each grant.
//    rvalid_o[resp_idx] = resp_vld, exactly 1 cycle after the grant.
//    Reads and writes both produce exactly one rvalid; for writes rdata_o is don't-care.
//  - rdata_o = mem_rdata_i (pass-through, no register).
//  - A response and a new grant can occur in the same cycle, to the same or different ports.
//  - Reset values: rr_ptr = NUM_PORTS-1 (port 0 has first priority); resp_vld=0;
//    resp_idx=0; grant_idx_o=0. All outputs are inactive in the reset cycle.
//  - Reset mid-operation: a response pending at reset is dropped; no rvalid_o follows reset.
//    A grant is never issued while rst_i=1.
//  - Index arithmetic is IDX_W bits with explicit wrap at NUM_PORTS, so a non-power-of-2
//    NUM_PORTS never selects an out-of-range index.
// CONFIGURATION
//  Macro MEM_PORT_ARBITER_OUT_REG_EN:
//  - Undefined: mem_* outputs are combinational as above; rvalid_o follows gnt_o by 1 cycle.
//  - Defined: mem_req/we/addr/be/wdata are registered (mem_req_o resets to 0).
//    * gnt_o is still issued in the arbitration cycle.
//    * The SRAM sees the access 1 cycle after the grant; rvalid_o follows gnt_o by 2 cycles.
//    * Response tracking becomes a 2-deep shift of (vld, idx).
//    * Throughput remains one access per cycle.
//    * Reset clears both stages of the response shift.
// TESTING
//  1 Reset: hold rst_i 3 cycles with all req_i=1.
//    -> gnt_o=0, rvalid_o=0, mem_req_o=0.
//    First cycle after release: gnt_o=3'b001.
//  2 Single read: port 1 reads addr 0x80000010 (SRAM preloaded with 0xDEADBEEF).
//    -> gnt_o=3'b010 same cycle; rvalid_o=3'b010 with rdata_o=0xDEADBEEF
//       next cycle (+2 with the macro).
//  3 Contention: all three ports request continuously for 6 cycles.
//    -> grant sequence 0,1,2,0,1,2; rvalid sequence identical, lagging 1 cycle.
//  4 Write then read: port 2 writes 0x12345678 with be=4'b0011 to 0x80000020 over old
//    value 0xFFFFFFFF, then reads it.
//    -> two rvalids to port 2; read returns 0xFFFF5678.
//  5 Reset mid-operation: assert rst_i in the cycle after port 0's grant.
//    -> no rvalid_o for that access; rr_ptr returns to 2.
//  6 Non-power-of-2 wrap: NUM_PORTS=3, only port 2 then only port 0 request.
//    -> grant index 2 then 0 with no bubble; never index 3.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and SRAM-side signal bundle for mem_port_arbiter.
// slave = the arbiter, master = requesters plus the SRAM macro.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]            req_i;
  logic [NUM_PORTS-1:0]            gnt_o;
  logic [NUM_PORTS-1:0]            we_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_PORTS*BE_W-1:0]       be_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_PORTS-1:0]            rvalid_o;
  logic [DATA_WIDTH-1:0]           rdata_o;

  logic                            mem_req_o;
  logic                            mem_we_o;
  logic [ADDR_WIDTH-1:0]           mem_addr_o;
  logic [BE_W-1:0]                 mem_be_o;
  logic [DATA_WIDTH-1:0]           mem_wdata_o;
  logic [DATA_WIDTH-1:0]           mem_rdata_i;
  logic [IDX_W-1:0]                grant_idx_o;

  modport slave (
    input  req_i, we_i, addr_i, be_i, wdata_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, grant_idx_o
  );

  modport master (
    output req_i, we_i, addr_i, be_i, wdata_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, grant_idx_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency SRAM between NUM_PORTS req/gnt/rvalid masters.
// Define MEM_PORT_ARBITER_OUT_REG_EN to register the SRAM-side outputs (rvalid lags gnt by 2).
module mem_port_arbiter #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.slave   bus
);
  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int BE_W  = DATA_WIDTH / 8;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(NUM_PORTS - 1);

  // Explicit wrap keeps non-power-of-2 port counts in range.
  function automatic idx_t wrap_inc(input idx_t i);
    return (i == LAST_IDX) ? '0 : idx_t'(i + 1'b1);
  endfunction

  idx_t                  rr_ptr;
  idx_t                  grant_idx_q;
  idx_t                  win_idx;
  idx_t                  sel;
  logic                  grant;
  logic [NUM_PORTS-1:0]  gnt;

  logic                  mux_we;
  logic [ADDR_WIDTH-1:0] mux_addr;
  logic [BE_W-1:0]       mux_be;
  logic [DATA_WIDTH-1:0] mux_wdata;

  logic                  out_vld;
  idx_t                  out_idx;
  logic [NUM_PORTS-1:0]  rvalid;

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin : arbitrate
    idx_t cand;
    grant   = 1'b0;
    win_idx = '0;
    gnt     = '0;
    cand    = rr_ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = wrap_inc(cand);
      if (!grant && bus.req_i[cand]) begin
        grant   = 1'b1;
        win_idx = cand;
      end
    end
    if (rst_i) grant = 1'b0;
    if (grant) gnt[win_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= LAST_IDX;
      grant_idx_q <= '0;
    end else if (grant) begin
      rr_ptr      <= win_idx;
      grant_idx_q <= win_idx;
    end
  end

  // Idle cycles select port 0 so the SRAM fields never float to X.
  always_comb begin
    sel       = grant ? win_idx : '0;
    mux_we    = bus.we_i[sel];
    mux_addr  = bus.addr_i[int'(sel) * ADDR_WIDTH +: ADDR_WIDTH];
    mux_be    = bus.be_i[int'(sel) * BE_W +: BE_W];
    mux_wdata = bus.wdata_i[int'(sel) * DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef MEM_PORT_ARBITER_OUT_REG_EN
  logic [1:0]            resp_vld;
  idx_t                  resp_idx [2];
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [BE_W-1:0]       mem_be_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_vld    <= '0;
      resp_idx[0] <= '0;
      resp_idx[1] <= '0;
      mem_req_q   <= 1'b0;
    end else begin
      resp_vld    <= {resp_vld[0], grant};
      resp_idx[0] <= win_idx;
      resp_idx[1] <= resp_idx[0];
      mem_req_q   <= grant;
    end
  end

  // Data fields only qualify mem_req, so they carry no reset.
  always_ff @(posedge clk_i) begin
    mem_we_q    <= mux_we;
    mem_addr_q  <= mux_addr;
    mem_be_q    <= mux_be;
    mem_wdata_q <= mux_wdata;
  end

  assign out_vld         = resp_vld[1];
  assign out_idx         = resp_idx[1];
  assign bus.mem_req_o   = mem_req_q && !rst_i;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_be_o    = mem_be_q;
  assign bus.mem_wdata_o = mem_wdata_q;
`else
  logic resp_vld;
  idx_t resp_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_vld <= 1'b0;
      resp_idx <= '0;
    end else begin
      resp_vld <= grant;
      if (grant) resp_idx <= win_idx;
    end
  end

  assign out_vld         = resp_vld;
  assign out_idx         = resp_idx;
  assign bus.mem_req_o   = grant;
  assign bus.mem_we_o    = mux_we;
  assign bus.mem_addr_o  = mux_addr;
  assign bus.mem_be_o    = mux_be;
  assign bus.mem_wdata_o = mux_wdata;
`endif

  // A response still in flight when reset arrives is suppressed.
  always_comb begin
    rvalid = '0;
    if (out_vld && !rst_i) rvalid[out_idx] = 1'b1;
  end

  assign bus.gnt_o       = gnt;
  assign bus.rvalid_o    = rvalid;
  assign bus.rdata_o     = bus.mem_rdata_i;
  assign bus.grant_idx_o = grant_idx_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model and a behavioural SRAM.
module tb_mem_port_arbiter;
  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef MEM_PORT_ARBITER_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int          cyc;
    int          idx;
    bit          we;
    logic [DW-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst_i;

  mem_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Requester-side stimulus state
  logic [NP-1:0] req_v;
  logic [NP-1:0] we_v;
  logic [AW-1:0] addr_v  [NP];
  logic [BW-1:0] be_v    [NP];
  logic [DW-1:0] wdata_v [NP];

  // Reference model state
  int            n_vec = 0;
  int            n_bad = 0;
  int            cyc   = 0;
  int            rr;
  int            gi;
  resp_t         resp_q [$];
  logic [DW-1:0] ref_mem [64];

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'hFFFFFFFF;
    return {8'(i), ~8'(i), 8'(i * 3), 8'h5A};
  endfunction

  // Behavioural SRAM: one-cycle read latency, byte-enabled writes.
  logic [DW-1:0] sram [64];
  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
    end else if (bus.mem_req_o) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < BW; b++)
          if (bus.mem_be_o[b]) sram[bus.mem_addr_o[7:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end else begin
        bus.mem_rdata_i <= sram[bus.mem_addr_o[7:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    bus.req_i = req_v;
    bus.we_i  = we_v;
    for (int p = 0; p < NP; p++) begin
      bus.addr_i[p*AW +: AW]  = addr_v[p];
      bus.be_i[p*BW +: BW]    = be_v[p];
      bus.wdata_i[p*DW +: DW] = wdata_v[p];
    end
  endtask

  task automatic set_port(input int p, input bit we, input logic [AW-1:0] a,
                          input logic [BW-1:0] be, input logic [DW-1:0] wd);
    req_v[p]   = 1'b1;
    we_v[p]    = we;
    addr_v[p]  = a;
    be_v[p]    = be;
    wdata_v[p] = wd;
  endtask

  // One clock: drive inputs after the edge, check at the falling edge, advance the model.
  task automatic step(input logic rst, output logic [NP-1:0] g,
                      output logic [NP-1:0] rv, output logic [DW-1:0] rd);
    int            win;
    int            c;
    int            w;
    logic [NP-1:0] eg;
    logic [NP-1:0] erv;
    logic [DW-1:0] mask;
    resp_t         r;
    @(posedge clk);
    #1;
    rst_i = rst;
    drive();
    @(negedge clk);
    cyc++;
    g  = bus.gnt_o;
    rv = bus.rvalid_o;
    rd = bus.rdata_o;
    if (rst) begin
      check("rst_gnt", 64'(g), 64'(0));
      check("rst_rvalid", 64'(rv), 64'(0));
      check("rst_mem_req", 64'(bus.mem_req_o), 64'(0));
      rr = NP - 1;
      gi = 0;
      resp_q.delete();
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      return;
    end
    check("grant_idx", 64'(bus.grant_idx_o), 64'(gi));
    win = -1;
    for (int k = 1; k <= NP; k++) begin
      c = (rr + k) % NP;
      if (win < 0 && req_v[c]) win = c;
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    check("gnt", 64'(g), 64'(eg));
`ifndef MEM_PORT_ARBITER_OUT_REG_EN
    check("mem_req", 64'(bus.mem_req_o), 64'(win >= 0));
    c = (win >= 0) ? win : 0;
    check("mem_addr", 64'(bus.mem_addr_o), 64'(addr_v[c]));
    if (win >= 0) begin
      check("mem_we", 64'(bus.mem_we_o), 64'(we_v[c]));
      check("mem_be", 64'(bus.mem_be_o), 64'(be_v[c]));
      check("mem_wdata", 64'(bus.mem_wdata_o), 64'(wdata_v[c]));
    end
`endif
    erv = '0;
    if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
      r = resp_q.pop_front();
      erv[r.idx] = 1'b1;
      if (!r.we) check("rdata", 64'(rd), 64'(r.data));
    end
    check("rvalid", 64'(rv), 64'(erv));
    if (win >= 0) begin
      rr = win;
      gi = win;
      w  = int'(addr_v[win][7:2]);
      if (we_v[win]) begin
        mask = '0;
        for (int b = 0; b < BW; b++) if (be_v[win][b]) mask |= DW'(32'hFF) << (8 * b);
        ref_mem[w] = (ref_mem[w] & ~mask) | (wdata_v[win] & mask);
      end
      resp_q.push_back('{cyc + LAT, win, we_v[win], ref_mem[w]});
      req_v[win] = 1'b0;
    end
  endtask

  initial begin
    logic [NP-1:0] g;
    logic [NP-1:0] rv;
    logic [DW-1:0] rd;
    int            cnt;
    int            seq [6] = '{0, 1, 2, 0, 1, 2};

    rst_i           = 1'b1;
    bus.mem_rdata_i = '0;
    req_v           = '0;
    we_v            = '0;
    for (int p = 0; p < NP; p++) begin
      addr_v[p]  = 32'h8000_0000;
      be_v[p]    = '1;
      wdata_v[p] = '0;
    end
    drive();

    // Reset held with every port requesting, then continuous contention.
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, 32'h8000_0000 + 32'(4 * p), 4'hF, '0);
    repeat (3) step(1'b1, g, rv, rd);
    for (int i = 0; i < 6; i++) begin
      req_v = '1;
      step(1'b0, g, rv, rd);
      check("contend_gnt", 64'(g), 64'(1) << seq[i]);
    end
    req_v = '0;
    repeat (3) step(1'b0, g, rv, rd);

    // Single read from port 1.
    set_port(1, 1'b0, 32'h8000_0010, 4'hF, '0);
    step(1'b0, g, rv, rd);
    check("rd1_gnt", 64'(g), 64'b010);
    repeat (LAT) step(1'b0, g, rv, rd);
    check("rd1_rvalid", 64'(rv), 64'b010);
    check("rd1_rdata", 64'(rd), 64'hDEADBEEF);

    // Partial write then read-back on port 2.
    cnt = 0;
    set_port(2, 1'b1, 32'h8000_0020, 4'b0011, 32'h1234_5678);
    step(1'b0, g, rv, rd);
    cnt += int'(rv[2]);
    set_port(2, 1'b0, 32'h8000_0020, 4'hF, '0);
    step(1'b0, g, rv, rd);
    cnt += int'(rv[2]);
    for (int i = 0; i < LAT; i++) begin
      step(1'b0, g, rv, rd);
      cnt += int'(rv[2]);
    end
    check("wr_rd_rdata", 64'(rd), 64'hFFFF_5678);
    repeat (2) begin
      step(1'b0, g, rv, rd);
      cnt += int'(rv[2]);
    end
    check("wr_rd_rvalid_count", 64'(cnt), 64'(2));

    // Reset in the cycle after a grant drops the response.
    set_port(0, 1'b0, 32'h8000_0010, 4'hF, '0);
    step(1'b0, g, rv, rd);
    check("mid_rst_gnt", 64'(g), 64'b001);
    step(1'b1, g, rv, rd);
    cnt = 0;
    repeat (3) begin
      step(1'b0, g, rv, rd);
      cnt += int'(|rv);
    end
    check("mid_rst_no_rvalid", 64'(cnt), 64'(0));
    req_v = '1;
    step(1'b0, g, rv, rd);
    check("post_rst_gnt", 64'(g), 64'b001);
    req_v = '0;
    repeat (3) step(1'b0, g, rv, rd);

    // Wrap from the last port back to port 0 without a bubble.
    set_port(2, 1'b0, 32'h8000_0004, 4'hF, '0);
    step(1'b0, g, rv, rd);
    check("wrap_gnt2", 64'(g), 64'b100);
    set_port(0, 1'b0, 32'h8000_0008, 4'hF, '0);
    step(1'b0, g, rv, rd);
    check("wrap_gnt0", 64'(g), 64'b001);
    step(1'b0, g, rv, rd);
    check("wrap_idx", 64'(bus.grant_idx_o), 64'(0));
    repeat (2) step(1'b0, g, rv, rd);

    // Random traffic; pending requests stay stable until granted.
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req_v[p] && $urandom_range(0, 99) < 45)
          set_port(p, 1'($urandom_range(0, 1)), 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2),
                   BW'($urandom), DW'($urandom));
      end
      step($urandom_range(0, 99) < 1, g, rv, rd);
    end
    for (int i = 0; i < 20 && (req_v != '0 || resp_q.size() > 0); i++) step(1'b0, g, rv, rd);
    check("drain_outstanding", 64'(resp_q.size()), 64'(0));
    check("drain_pending", 64'(req_v), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
